// File: rtl/adc_rx_align_ctrl.sv
// adc_rx_align_ctrl: GDDRX2 ADC word-alignment sequencer (CLKDIVF reset, ALIGNWD slips, lock/fail).
// Optional mismatch counter on o_err_cnt is built when ADC_ALIGN_ERR_CNT_EN is defined.
module adc_rx_align_ctrl #(
    parameter logic [15:0] TRAIN_PAT   = 16'hA55A,
    parameter int          DIV_RST_CYC = 8,
    parameter int          SETTLE_CYC  = 16,
    parameter int          MATCH_CYC   = 32,
    parameter int          MAX_SLIPS   = 8
) (
    input  logic        i_clk,
    input  logic        i_srst,
    input  logic        i_start,
    input  logic [15:0] i_chan_a_sample_0,
    input  logic [15:0] i_chan_a_sample_1,
    input  logic [15:0] i_chan_b_sample_0,
    input  logic [15:0] i_chan_b_sample_1,
    output logic        o_clkdiv_rst,
    output logic        o_alignwd,
    output logic        o_busy,
    output logic        o_locked,
    output logic        o_fail,
    output logic [3:0]  o_slip_cnt,
    output logic [15:0] o_err_cnt
);

    localparam int DIV_W    = (DIV_RST_CYC > 1) ? $clog2(DIV_RST_CYC) : 1;
    localparam int SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int MATCH_W  = (MATCH_CYC > 1) ? $clog2(MATCH_CYC) : 1;

    localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(DIV_RST_CYC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(MATCH_CYC - 1);
    localparam logic [3:0]          SLIP_MAX    = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DIV_RST,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [MATCH_W-1:0]  match_cnt_q, match_cnt_d;
    logic [3:0]          slip_cnt_q, slip_cnt_d;

    logic clkdiv_rst_q, clkdiv_rst_d;
    logic alignwd_q, alignwd_d;
    logic busy_q, busy_d;
    logic locked_q, locked_d;
    logic fail_q, fail_d;

    logic [15:0] a0_q, a1_q, b0_q, b1_q;
    logic        match;
    logic        start_ok;

    // Capture the deserialised words so the compare works on a clean registered copy
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            a0_q <= '0;
            a1_q <= '0;
            b0_q <= '0;
            b1_q <= '0;
        end else begin
            a0_q <= i_chan_a_sample_0;
            a1_q <= i_chan_a_sample_1;
            b0_q <= i_chan_b_sample_0;
            b1_q <= i_chan_b_sample_1;
        end
    end

    assign match = (a0_q == TRAIN_PAT) && (a1_q == TRAIN_PAT) &&
                   (b0_q == TRAIN_PAT) && (b1_q == TRAIN_PAT);

    // A start is only taken from a resting state; pulses mid-attempt are dropped
    assign start_ok = i_start &&
                      ((state_q == S_IDLE) || (state_q == S_LOCKED) ||
                       (state_q == S_FAIL));

    // Sequencer next-state, counters and the registered output values
    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        settle_cnt_d = settle_cnt_q;
        match_cnt_d  = match_cnt_q;
        slip_cnt_d   = slip_cnt_q;

        unique case (state_q)
            S_IDLE, S_LOCKED, S_FAIL: begin
                if (start_ok) begin
                    state_d    = S_DIV_RST;
                    div_cnt_d  = '0;
                    slip_cnt_d = '0;
                end
            end
            S_DIV_RST: begin
                if (div_cnt_q == DIV_LAST) begin
                    state_d      = S_SETTLE;
                    settle_cnt_d = '0;
                    match_cnt_d  = '0;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (match) begin
                    if (match_cnt_q == MATCH_LAST) begin
                        state_d = S_LOCKED;
                    end else begin
                        match_cnt_d = match_cnt_q + 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                    if (slip_cnt_q == SLIP_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        state_d    = S_SLIP;
                        slip_cnt_d = slip_cnt_q + 1'b1;
                    end
                end
            end
            S_SLIP: begin
                state_d      = S_SETTLE;
                settle_cnt_d = '0;
                match_cnt_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        clkdiv_rst_d = (state_d == S_DIV_RST);
        alignwd_d    = (state_d == S_SLIP);
        busy_d       = (state_d == S_DIV_RST) || (state_d == S_SETTLE) ||
                       (state_d == S_CHECK) || (state_d == S_SLIP);
        locked_d     = (state_d == S_LOCKED);
        fail_d       = (state_d == S_FAIL);
    end

    // State, counters and outputs; reset drops every output on the next edge
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q      <= S_IDLE;
            div_cnt_q    <= '0;
            settle_cnt_q <= '0;
            match_cnt_q  <= '0;
            slip_cnt_q   <= '0;
            clkdiv_rst_q <= 1'b0;
            alignwd_q    <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            match_cnt_q  <= match_cnt_d;
            slip_cnt_q   <= slip_cnt_d;
            clkdiv_rst_q <= clkdiv_rst_d;
            alignwd_q    <= alignwd_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
        end
    end

    assign o_clkdiv_rst = clkdiv_rst_q;
    assign o_alignwd    = alignwd_q;
    assign o_busy       = busy_q;
    assign o_locked     = locked_q;
    assign o_fail       = fail_q;
    assign o_slip_cnt   = slip_cnt_q;

`ifdef ADC_ALIGN_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    // Count mismatching compare cycles in CHECK; saturate rather than wrap
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_ok) begin
            err_cnt_d = '0;
        end else if ((state_q == S_CHECK) && !match &&
                     (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Mismatch counter register
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
`else
    assign o_err_cnt = 16'h0000;
`endif

endmodule
